// File: rtl/tm1638_frame_driver.sv
// TM1638 frame engine: data cmd, address burst, display control.
// Optional key read frame enabled by defining TM1638_KEY_SCAN_EN.
module tm1638_frame_driver #(
    parameter int NUM_GRIDS  = 8,
    parameter int CLK_DIV    = 4,
    parameter int GAP_HALVES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [NUM_GRIDS*8-1:0] segments_i,
    input  logic [NUM_GRIDS-1:0]   leds_i,
    input  logic [2:0]             brightness_i,
    input  logic                   display_on_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   stb_o,
    output logic                   sclk_o,
    output logic                   dio_o,
    output logic                   dio_oe_o,
    input  logic                   dio_i,
    output logic [31:0]            keys_o,
    output logic                   keys_valid_o
);

    if (NUM_GRIDS < 1 || NUM_GRIDS > 8) begin : g_bad_grids
        $error("NUM_GRIDS must be in 1..8");
    end
    if (CLK_DIV < 1 || GAP_HALVES < 1) begin : g_bad_timing
        $error("CLK_DIV and GAP_HALVES must be >= 1");
    end

`ifdef TM1638_KEY_SCAN_EN
    localparam bit         KEY_EN     = 1'b1;
    localparam logic [1:0] LAST_FRAME = 2'd3;
`else
    localparam bit         KEY_EN     = 1'b0;
    localparam logic [1:0] LAST_FRAME = 2'd2;
`endif

    localparam int BW   = $clog2(2 * NUM_GRIDS + 2);
    localparam int GAPC = GAP_HALVES * CLK_DIV;
    localparam int MAXC = (GAPC > 2 * CLK_DIV) ? GAPC : 2 * CLK_DIV;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        IDLE, LATCH, FRAME_START, BIT_LOW, BIT_HIGH,
        FRAME_END, TWAIT, GAP, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [1:0]               frame_q, frame_d;
    logic [BW-1:0]            byte_q, byte_d;
    logic [2:0]               bit_q, bit_d;
    logic                     rd_q, rd_d;
    logic                     dio_q, dio_d;
    logic [NUM_GRIDS*8-1:0]   seg_q, seg_d;
    logic [NUM_GRIDS-1:0]     led_q, led_d;
    logic [2:0]               bri_q, bri_d;
    logic                     on_q, on_d;
    logic [31:0]              ksh_q, ksh_d;
    logic [31:0]              keys_q, keys_d;

    logic [BW-1:0]            sel_byte;
    logic [2:0]               sel_bit;
    logic [7:0]               cur_byte;
    logic [BW-1:0]            last_byte;

    // Pick the byte/bit that goes on DIO at the next BIT_LOW entry
    always_comb begin
        sel_byte = byte_q;
        sel_bit  = bit_q;
        if (state_q == BIT_HIGH) begin
            sel_bit = bit_q + 3'd1;
            if (bit_q == 3'd7) sel_byte = byte_q + BW'(1);
        end
        cur_byte = 8'h00;
        case (frame_q)
            2'd0: cur_byte = 8'h40;
            2'd1: begin
                if (sel_byte == '0) cur_byte = 8'hC0;
                for (int g = 0; g < NUM_GRIDS; g++) begin
                    if (sel_byte == BW'(2 * g + 1)) cur_byte = seg_q[8*g +: 8];
                    if (sel_byte == BW'(2 * g + 2)) cur_byte = {7'b0, led_q[g]};
                end
            end
            2'd2:    cur_byte = {4'h8, on_q, bri_q};
            default: cur_byte = 8'h42;
        endcase
        if (rd_q)                last_byte = BW'(3);
        else if (frame_q == 2'd1) last_byte = BW'(2 * NUM_GRIDS);
        else                     last_byte = '0;
    end

    // Sequencer: frame/byte/bit walk with half-bit timing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        dio_d   = dio_q;
        seg_d   = seg_q;
        led_d   = led_q;
        bri_d   = bri_q;
        on_d    = on_q;
        ksh_d   = ksh_q;
        keys_d  = keys_q;
        case (state_q)
            IDLE: begin
                dio_d = 1'b1;
                if (start_i) begin
                    seg_d   = segments_i;
                    led_d   = leds_i;
                    bri_d   = brightness_i;
                    on_d    = display_on_i;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d = FRAME_START;
                cnt_d   = '0;
                frame_d = 2'd0;
                byte_d  = '0;
                bit_d   = 3'd0;
                rd_d    = 1'b0;
                ksh_d   = '0;
            end
            FRAME_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    dio_d   = cur_byte[sel_bit];
                    state_d = BIT_LOW;
                end
            end
            BIT_LOW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (KEY_EN && rd_q) ksh_d = {dio_i, ksh_q[31:1]};
                    if (bit_q == 3'd7 && byte_q == last_byte) begin
                        byte_d = '0;
                        if (KEY_EN && frame_q == 2'd3 && !rd_q) begin
                            rd_d    = 1'b1;
                            state_d = TWAIT;
                        end else begin
                            state_d = FRAME_END;
                        end
                    end else begin
                        if (bit_q == 3'd7) byte_d = byte_q + BW'(1);
                        if (!rd_q) dio_d = cur_byte[sel_bit];
                        state_d = BIT_LOW;
                    end
                end
            end
            TWAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = BIT_LOW;
                end
            end
            FRAME_END: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    rd_d    = 1'b0;
                    if (KEY_EN && frame_q == 2'd3) keys_d = ksh_q;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GAPC - 1)) begin
                    cnt_d  = '0;
                    byte_d = '0;
                    bit_d  = 3'd0;
                    if (frame_q == LAST_FRAME) begin
                        state_d = DONE;
                    end else begin
                        frame_d = frame_q + 2'd1;
                        state_d = FRAME_START;
                    end
                end
            end
            DONE: begin
                dio_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= 2'd0;
            byte_q  <= '0;
            bit_q   <= 3'd0;
            rd_q    <= 1'b0;
            dio_q   <= 1'b1;
            seg_q   <= '0;
            led_q   <= '0;
            bri_q   <= 3'd0;
            on_q    <= 1'b0;
            ksh_q   <= '0;
            keys_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            dio_q   <= dio_d;
            seg_q   <= seg_d;
            led_q   <= led_d;
            bri_q   <= bri_d;
            on_q    <= on_d;
            ksh_q   <= ksh_d;
            keys_q  <= keys_d;
        end
    end

    // Pin levels decoded from the current state
    always_comb begin
        stb_o        = !(state_q inside {FRAME_START, BIT_LOW, BIT_HIGH,
                                         FRAME_END, TWAIT});
        sclk_o       = (state_q != BIT_LOW);
        dio_o        = dio_q;
        dio_oe_o     = !(KEY_EN && rd_q &&
                         (state_q inside {TWAIT, BIT_LOW, BIT_HIGH}));
        busy_o       = (state_q != IDLE) && (state_q != DONE);
        done_o       = (state_q == DONE);
        keys_o       = keys_q;
        keys_valid_o = KEY_EN && (state_q == DONE);
    end

endmodule

// File: tb/tb_tm1638_frame_driver.sv
// Directed bench for tm1638_frame_driver: decodes the STB/CLK/DIO
// stream and compares bytes and STB-low lengths against a scoreboard.
module tb_tm1638_frame_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [63:0] seg_a = '0;
    logic [23:0] seg_b = '0;
    logic [7:0]  led_a = '0;
    logic [2:0]  led_b = '0;
    logic [2:0]  bri_a = '0, bri_b = '0;
    logic        on_a = 1'b0, on_b = 1'b0;
    logic        dio_in_a = 1'b1, dio_in_b = 1'b1;

    logic        busy_a, done_a, stb_a, sclk_a, dio_a, oe_a, kv_a;
    logic        busy_b, done_b, stb_b, sclk_b, dio_b, oe_b, kv_b;
    logic [31:0] keys_a, keys_b;

    tm1638_frame_driver #(.NUM_GRIDS(8), .CLK_DIV(2), .GAP_HALVES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a),
        .segments_i(seg_a), .leds_i(led_a), .brightness_i(bri_a),
        .display_on_i(on_a), .busy_o(busy_a), .done_o(done_a),
        .stb_o(stb_a), .sclk_o(sclk_a), .dio_o(dio_a), .dio_oe_o(oe_a),
        .dio_i(dio_in_a), .keys_o(keys_a), .keys_valid_o(kv_a)
    );

    tm1638_frame_driver #(.NUM_GRIDS(3), .CLK_DIV(1), .GAP_HALVES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b),
        .segments_i(seg_b), .leds_i(led_b), .brightness_i(bri_b),
        .display_on_i(on_b), .busy_o(busy_b), .done_o(done_b),
        .stb_o(stb_b), .sclk_o(sclk_b), .dio_o(dio_b), .dio_oe_o(oe_b),
        .dio_i(dio_in_b), .keys_o(keys_b), .keys_valid_o(kv_b)
    );

    logic sel = 1'b0;
    logic stb_m, sclk_m, dio_m, oe_m, done_m, busy_m;
    assign stb_m  = sel ? stb_b  : stb_a;
    assign sclk_m = sel ? sclk_b : sclk_a;
    assign dio_m  = sel ? dio_b  : dio_a;
    assign oe_m   = sel ? oe_b   : oe_a;
    assign done_m = sel ? done_b : done_a;
    assign busy_m = sel ? busy_b : busy_a;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    int         exp_len[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frames(input int ng, input int cd,
                               input logic [63:0] seg, input logic [7:0] led,
                               input logic [2:0] br, input logic on);
        exp_bytes.push_back(8'h40);
        exp_len.push_back(cd * 18);
        exp_bytes.push_back(8'hC0);
        for (int g = 0; g < ng; g++) begin
            exp_bytes.push_back(seg[8*g +: 8]);
            exp_bytes.push_back({7'b0, led[g]});
        end
        exp_len.push_back(cd * (2 + 16 * (2 * ng + 1)));
        exp_bytes.push_back(8'h80 | (8'(on) << 3) | 8'(br));
        exp_len.push_back(cd * 18);
`ifdef TM1638_KEY_SCAN_EN
        exp_bytes.push_back(8'h42);
        exp_len.push_back(cd * 84);
`endif
    endtask

    // Bus decoder and scoreboard consumer
    logic       mon_en = 1'b0;
    logic       p_stb = 1'b1, p_sclk = 1'b1, p_dio = 1'b1;
    logic [7:0] sh = '0;
    int         nb = 0, lowc = 0, oe_low = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            nb = 0;
            lowc = 0;
        end else begin
            if (!stb_m) begin
                lowc++;
                if (!p_sclk && sclk_m && oe_m) begin
                    sh = {dio_m, sh[7:1]};
                    nb++;
                    if (nb == 8) begin
                        nb = 0;
                        checks++;
                        assert (exp_bytes.size() > 0) else begin
                            errors++;
                            $error("FAIL extra_byte: got %0h expected none", sh);
                        end
                        if (exp_bytes.size() > 0)
                            chk("byte", sh, exp_bytes.pop_front());
                    end
                end
                if (!p_stb && dio_m !== p_dio)
                    chk("dio_change_sclk", sclk_m, 1'b0);
            end
            if (!oe_m) oe_low++;
            if (!p_stb && stb_m) begin
                checks++;
                assert (exp_len.size() > 0) else begin
                    errors++;
                    $error("FAIL extra_frame: got len %0d expected none", lowc);
                end
                if (exp_len.size() > 0)
                    chk("stb_low_len", lowc, exp_len.pop_front());
                chk("frame_bits", nb, 0);
                lowc = 0;
                nb = 0;
            end
            if (done_m) done_cnt++;
        end
        p_stb = stb_m;
        p_sclk = sclk_m;
        p_dio = dio_m;
    end

    // Key matrix model for DUT A: next bit on each read-phase CLK fall
    logic [31:0] kimg = 32'h80100001;
    int          kbit = 0;
    logic        kp_sclk = 1'b1;
    always @(negedge clk) begin
        if (!oe_a && kp_sclk && !sclk_a && kbit < 32) begin
            dio_in_a = kimg[kbit];
            kbit++;
        end
        kp_sclk = sclk_a;
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_m && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (done_m) else begin
            errors++;
            $error("FAIL done_timeout: got %0d cycles expected done", n);
        end
    endtask

    task automatic run_end_checks(input int cd);
        repeat (30) @(negedge clk);
        chk("busy_after", busy_m, 1'b0);
        chk("stb_after", stb_m, 1'b1);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("frames_left", exp_len.size(), 0);
        chk("done_count", done_cnt, 1);
`ifdef TM1638_KEY_SCAN_EN
        chk("oe_low_cycles", oe_low, 66 * cd);
`else
        chk("oe_low_cycles", oe_low, 0 * cd);
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stb", stb_a, 1'b1);
        chk("rst_sclk", sclk_a, 1'b1);
        chk("rst_dio", {dio_a, oe_a}, 2'b11);
        chk("rst_busy_done", {busy_a, done_a}, 2'b00);
        chk("rst_keys", {kv_a, keys_a}, 33'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted mid-F2
        seg_a = {8{8'h3F}};
        led_a = 8'hA5;
        bri_a = 3'd7;
        on_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_stb_low", stb_a, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_stb", stb_a, 1'b1);
        chk("midrst_sclk", sclk_a, 1'b1);
        chk("midrst_busy", busy_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full 8-grid refresh with late stimulus changes
        mon_en = 1'b1;
        done_cnt = 0;
        oe_low = 0;
        kbit = 0;
        push_frames(8, 2, seg_a, led_a, bri_a, on_a);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_rise", busy_a, 1'b1);
        repeat (150) @(negedge clk);
        seg_a = '0;
        led_a = 8'h00;
        bri_a = 3'd0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(5000);
        chk("busy_at_done", busy_a, 1'b0);
`ifdef TM1638_KEY_SCAN_EN
        chk("keys_valid_at_done", kv_a, 1'b1);
        chk("keys_value", keys_a, 32'h80100001);
`else
        chk("keys_valid_off", kv_a, 1'b0);
        chk("keys_off", keys_a, 32'h0);
`endif
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        run_end_checks(2);

        // 3-grid, single-cycle half bits, edge bit pattern
        sel = 1'b1;
        repeat (2) @(negedge clk);
        done_cnt = 0;
        oe_low = 0;
        seg_b = {8'h12, 8'h5A, 8'h80};
        led_b = 3'b010;
        bri_b = 3'd2;
        on_b = 1'b0;
        push_frames(3, 1, {40'h0, seg_b}, {5'h0, led_b}, bri_b, on_b);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("busy_rise_b", busy_b, 1'b1);
        wait_done(2000);
        chk("busy_at_done_b", busy_b, 1'b0);
        run_end_checks(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
